if_id_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Holds the PC, drives the instruction-memory address, and latches the fetched instruction and PC+4 into IF/ID.
- Honours the load-use stall produced by the hazard unit and the branch/jump redirect resolved in ID.
- Exports the IF_ID rs/rt fields that the hazard unit compares against ID_EX_rt; keeps saturating stall/flush event counters for debug.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_id_stage_if.sv | 21 ++
 rtl/if_id_stage_pc_register.sv | 14 +
 rtl/if_id_stage.sv | 61 ++++++
 tb/tb_if_id_stage.sv | 134 +++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: instruction-format constants shared by fetch, decode and hazard logic
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  function automatic logic [REG_ADDR_W-1:0] rs_of(input logic [INSTR_W-1:0] i);
    return i[RS_MSB:RS_LSB];
  endfunction
  function automatic logic [REG_ADDR_W-1:0] rt_of(input logic [INSTR_W-1:0] i);
    return i[RT_MSB:RT_LSB];
  endfunction
endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: instruction-memory bus, ID-side control and IF/ID register outputs
interface if_id_stage_if;
  logic                              stallSignal;
  logic                              redirect;
  logic [31:0]                       redirect_pc;
  logic [31:0]                       imem_addr;
  logic [mips_pkg::INSTR_W-1:0]      imem_rdata;
  logic [mips_pkg::INSTR_W-1:0]      IF_ID_instr;
  logic [31:0]                       IF_ID_pcPlus4;
  logic                              IF_ID_valid;
  logic [mips_pkg::REG_ADDR_W-1:0]   IF_ID_rs;
  logic [mips_pkg::REG_ADDR_W-1:0]   IF_ID_rt;
  modport master (
    input  stallSignal, redirect, redirect_pc, imem_rdata,
    output imem_addr, IF_ID_instr, IF_ID_pcPlus4, IF_ID_valid, IF_ID_rs, IF_ID_rt
  );
  modport slave (
    output stallSignal, redirect, redirect_pc, imem_rdata,
    input  imem_addr, IF_ID_instr, IF_ID_pcPlus4, IF_ID_valid, IF_ID_rs, IF_ID_rt
  );
endinterface

// File: rtl/if_id_stage_pc_register.sv
// pc_register: program counter with sync reset and load enable
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);
  always_ff @(posedge clk)
    if (reset) pc_q <= RESET_PC;
    else if (en) pc_q <= pc_d;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch PC, IF/ID pipeline register and saturating stall/flush counters
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  if_id_stage_if.master     bus,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);
  logic [31:0]        pc_q, pc_d, pc_plus4;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pcplus4_q, pcplus4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d, flush_count_q, flush_count_d;
  logic               stall, redir;
  assign stall    = bus.stallSignal;
  assign redir    = bus.redirect & ~bus.stallSignal;
  assign pc_plus4 = pc_q + 32'd4;
  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .pc_d  (pc_d),
    .pc_q  (pc_q)
  );
  // stall holds everything; a redirect loads its word-aligned target and squashes the wrong-path fetch
  always_comb begin
    pc_d          = redir ? (bus.redirect_pc & ~32'h3) : pc_plus4;
    instr_d       = stall ? instr_q   : redir ? NOP_INSTR : bus.imem_rdata;
    pcplus4_d     = stall ? pcplus4_q : redir ? 32'h0     : pc_plus4;
    valid_d       = stall ? valid_q   : ~redir;
    stall_count_d = (stall && ~&stall_count_q) ? stall_count_q + CNT_W'(1) : stall_count_q;
    flush_count_d = (redir && ~&flush_count_q) ? flush_count_q + CNT_W'(1) : flush_count_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      instr_q       <= NOP_INSTR;
      pcplus4_q     <= '0;
      valid_q       <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      instr_q       <= instr_d;
      pcplus4_q     <= pcplus4_d;
      valid_q       <= valid_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  assign bus.imem_addr     = pc_q;
  assign bus.IF_ID_instr   = instr_q;
  assign bus.IF_ID_pcPlus4 = pcplus4_q;
  assign bus.IF_ID_valid   = valid_q;
  assign bus.IF_ID_rs      = rs_of(instr_q);
  assign bus.IF_ID_rt      = rt_of(instr_q);
  assign stall_count       = stall_count_q;
  assign flush_count       = flush_count_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed vectors against hand-computed fetch/IF-ID expectations
module tb_if_id_stage;
  logic clk = 1'b0;
  logic reset, reset2;
  logic [15:0] stall_count, flush_count;
  logic [3:0]  stall_count2, flush_count2;
  int checks = 0;
  int errors = 0;
  if_id_stage_if bus ();
  if_id_stage_if bus2 ();
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h8C01_0004 : a == 32'h4 ? 32'h0022_1820 : a ^ 32'hDEAD_0000;
  endfunction
  assign bus.imem_rdata  = mem(bus.imem_addr);
  assign bus2.imem_rdata = mem(bus2.imem_addr);
  if_id_stage dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );
  if_id_stage #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset2),
    .bus         (bus2),
    .stall_count (stall_count2),
    .flush_count (flush_count2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                      input logic [31:0] pc4, input logic valid);
    check({tag, ".addr"}, bus.imem_addr, addr);
    check({tag, ".instr"}, bus.IF_ID_instr, instr);
    check({tag, ".pc4"}, bus.IF_ID_pcPlus4, pc4);
    check({tag, ".valid"}, {31'h0, bus.IF_ID_valid}, {31'h0, valid});
  endtask
  initial begin
    reset = 1'b1; reset2 = 1'b1;
    bus.stallSignal = 0; bus.redirect = 0; bus.redirect_pc = 0;
    bus2.stallSignal = 0; bus2.redirect = 0; bus2.redirect_pc = 0;
    step(); step();
    ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst.stall_cnt", {16'h0, stall_count}, 32'h0);
    check("rst.flush_cnt", {16'h0, flush_count}, 32'h0);
    reset = 1'b0;
    step();
    ifid("run1", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
    step();
    ifid("run2", 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    check("run2.rs", {27'h0, bus.IF_ID_rs}, 32'd1);
    check("run2.rt", {27'h0, bus.IF_ID_rt}, 32'd2);
    bus.stallSignal = 1;
    step();
    ifid("stall1", 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    step();
    ifid("stall2", 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    check("stall2.cnt", {16'h0, stall_count}, 32'd2);
    bus.stallSignal = 0;
    step();
    ifid("release", 32'hC, 32'hDEAD_0008, 32'hC, 1'b1);
    step();
    ifid("pc16", 32'h10, 32'hDEAD_000C, 32'h10, 1'b1);
    bus.redirect = 1; bus.redirect_pc = 32'h43;
    step();
    ifid("redir", 32'h40, 32'h0, 32'h0, 1'b0);
    check("redir.flush_cnt", {16'h0, flush_count}, 32'd1);
    check("redir.rs", {27'h0, bus.IF_ID_rs}, 32'd0);
    bus.redirect = 0;
    step();
    ifid("target", 32'h44, 32'hDEAD_0040, 32'h44, 1'b1);
    bus.stallSignal = 1; bus.redirect = 1; bus.redirect_pc = 32'h80;
    step();
    ifid("both", 32'h44, 32'hDEAD_0040, 32'h44, 1'b1);
    check("both.flush_cnt", {16'h0, flush_count}, 32'd1);
    check("both.stall_cnt", {16'h0, stall_count}, 32'd3);
    bus.stallSignal = 0;
    step();
    ifid("after_stall_redir", 32'h80, 32'h0, 32'h0, 1'b0);
    check("after_stall_redir.flush_cnt", {16'h0, flush_count}, 32'd2);
    bus.redirect_pc = 32'h200;
    step();
    check("redir2.addr", bus.imem_addr, 32'h200);
    bus.redirect_pc = 32'h300;
    step();
    ifid("redir3", 32'h300, 32'h0, 32'h0, 1'b0);
    check("redir3.flush_cnt", {16'h0, flush_count}, 32'd4);
    bus.redirect = 0;
    step();
    ifid("target3", 32'h304, 32'hDEAD_0300, 32'h304, 1'b1);
    bus.redirect = 1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 0; bus.stallSignal = 1;
    step();
    check("pre_rst.addr", bus.imem_addr, 32'h100);
    check("pre_rst.stall_cnt", {16'h0, stall_count}, 32'd4);
    reset = 1'b1;
    step();
    ifid("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("mid_rst.stall_cnt", {16'h0, stall_count}, 32'd0);
    check("mid_rst.flush_cnt", {16'h0, flush_count}, 32'd0);
    reset = 1'b0; bus.stallSignal = 0;
    step();
    ifid("refetch", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
    bus.redirect = 1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    check("top.addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect = 0;
    step();
    ifid("wrap", 32'h0, 32'h2152_FFFC, 32'h0, 1'b1);
    reset2 = 1'b0; bus2.stallSignal = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 14) check("sat.cnt14", {28'h0, stall_count2}, 32'hE);
      if (i == 15) check("sat.cnt15", {28'h0, stall_count2}, 32'hF);
    end
    check("sat.cnt17", {28'h0, stall_count2}, 32'hF);
    check("sat.addr", bus2.imem_addr, 32'h0);
    check("sat.flush", {28'h0, flush_count2}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
